exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit.sv | 147 ++++++++++++++
 tb/tb_exec_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Multi-cycle execute unit: fetches two operands from a registered-read register
// file, runs an 8-op ALU or a DATA_W-cycle shift-add multiply, then writes back.
module exec_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [ADDR_W-1:0] rf_read_port_1,
  output logic [ADDR_W-1:0] rf_read_port_2,
  input  logic [DATA_W-1:0] rf_read_data_1,
  input  logic [DATA_W-1:0] rf_read_data_2,
  output logic [ADDR_W-1:0] rf_write_port,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  output logic              done,
  output logic              busy,
  output logic              zero_flag,
  output logic              carry_flag
);

  // state   | meaning
  // ST_IDLE | waiting for an instruction, in_ready high
  // ST_RD   | read addresses presented, register file loads read data
  // ST_EX   | read data valid, operands captured on exit
  // ST_MUL  | shift-add multiply, one multiplier bit per cycle
  // ST_WB   | single write-back cycle with done pulse
  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_EX, ST_MUL, ST_WB} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t                state, state_nxt;
  logic [2:0]            op_q;
  logic [ADDR_W-1:0]     rd_q, rs1_q, rs2_q;
  logic [2*DATA_W-1:0]   mcand, acc, acc_nxt;
  logic [DATA_W-1:0]     mplier;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_W-1:0]     alu_res;
  logic                  alu_c;

  assign in_ready        = (state == ST_IDLE);
  assign busy            = !in_ready;
  assign rf_write_enable = (state == ST_WB);
  assign done            = (state == ST_WB) || ((state == ST_EX) && (op_q == OP_NOP));
  assign rf_read_port_1  = rs1_q;
  assign rf_read_port_2  = rs2_q;
  assign acc_nxt         = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD:  {alu_c, alu_res} = {1'b0, rf_read_data_1} + {1'b0, rf_read_data_2};
      OP_SUB:  {alu_c, alu_res} = {1'b0, rf_read_data_1} - {1'b0, rf_read_data_2};
      OP_AND:  alu_res = rf_read_data_1 & rf_read_data_2;
      OP_OR:   alu_res = rf_read_data_1 | rf_read_data_2;
      OP_XOR:  alu_res = rf_read_data_1 ^ rf_read_data_2;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(rf_read_data_1) < $signed(rf_read_data_2))};
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_RD;
      ST_RD:   state_nxt = ST_EX;
      ST_EX: begin
        if (op_q == OP_NOP)      state_nxt = ST_IDLE;
        else if (op_q == OP_MUL) state_nxt = ST_MUL;
        else                     state_nxt = ST_WB;
      end
      ST_MUL:  if (cnt == '0) state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      cnt           <= '0;
      rf_write_port <= '0;
      rf_write_data <= '0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (in_valid) begin
          op_q  <= opcode;
          rd_q  <= rd;
          rs1_q <= rs1;
          rs2_q <= rs2;
        end
        ST_EX: begin
          mcand  <= {{DATA_W{1'b0}}, rf_read_data_1};
          mplier <= rf_read_data_2;
          acc    <= '0;
          cnt    <= CNT_W'(DATA_W - 1);
          if (op_q != OP_MUL && op_q != OP_NOP) begin
            rf_write_port <= rd_q;
            rf_write_data <= alu_res;
            zero_flag     <= (alu_res == '0);
            carry_flag    <= alu_c;
          end
        end
        ST_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          // Final step: the result is the accumulator including this cycle's add.
          if (cnt == '0) begin
            rf_write_port <= rd_q;
            rf_write_data <= acc_nxt[DATA_W-1:0];
            zero_flag     <= (acc_nxt[DATA_W-1:0] == '0);
            carry_flag    <= |acc_nxt[2*DATA_W-1:DATA_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a behavioural registered-read register file
// and hand-computed results, flags and cycle timing.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] opcode = '0;
  logic [2:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0] rf_read_port_1, rf_read_port_2, rf_write_port;
  logic [7:0] rf_read_data_1, rf_read_data_2, rf_write_data;
  logic       rf_write_enable, done, busy, zero_flag, carry_flag;

  logic [7:0] rf_mem [8];
  logic       pl_en = 1'b0;
  logic [2:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  int total = 0, passed = 0, fails = 0;
  int we_cnt = 0, done_cnt = 0;
  int we_snap, done_snap;

  exec_unit #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .rf_read_port_1(rf_read_port_1), .rf_read_port_2(rf_read_port_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .rf_write_port(rf_write_port), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable), .done(done), .busy(busy),
    .zero_flag(zero_flag), .carry_flag(carry_flag)
  );

  always #5 clk = ~clk;

  // Register file: read data reloads only on edges without a write.
  always @(posedge clk) begin
    if (pl_en) rf_mem[pl_addr] <= pl_data;
    else if (rf_write_enable) rf_mem[rf_write_port] <= rf_write_data;
    if (!rf_write_enable) begin
      rf_read_data_1 <= rf_mem[rf_read_port_1];
      rf_read_data_2 <= rf_mem[rf_read_port_2];
    end
  end

  always @(posedge clk) begin
    if (rf_write_enable) we_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input string tag);
    @(negedge clk);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_accept_busy"}, 16'(busy), 16'h1);
  endtask

  // Called in the handshake cycle T; WB expected in cycle T+lat.
  task automatic wait_wb(input int lat, input logic [2:0] port, input logic [7:0] data,
                         input logic z, input logic c, input string tag);
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_pre_we"}, 16'(rf_write_enable), 16'h0);
      chk({tag, "_pre_done"}, 16'(done), 16'h0);
      step(1);
    end
    chk({tag, "_wb_we"}, 16'(rf_write_enable), 16'h1);
    chk({tag, "_wb_done"}, 16'(done), 16'h1);
    chk({tag, "_wb_port"}, 16'(rf_write_port), 16'(port));
    chk({tag, "_wb_data"}, 16'(rf_write_data), 16'(data));
    chk({tag, "_zero"}, 16'(zero_flag), 16'(z));
    chk({tag, "_carry"}, 16'(carry_flag), 16'(c));
    step(1);
    chk({tag, "_post_ready"}, 16'(in_ready), 16'h1);
    chk({tag, "_post_we"}, 16'(rf_write_enable), 16'h0);
    chk({tag, "_post_done"}, 16'(done), 16'h0);
  endtask

  initial begin
    #1;
    chk("rst_ready", 16'(in_ready), 16'h1);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_we", 16'(rf_write_enable), 16'h0);
    chk("rst_wport", 16'(rf_write_port), 16'h0);
    chk("rst_wdata", 16'(rf_write_data), 16'h0);
    chk("rst_flags", {14'h0, zero_flag, carry_flag}, 16'h0);
    chk("rst_rports", {10'h0, rf_read_port_1, rf_read_port_2}, 16'h0);

    preload(0, 8'h00); preload(1, 8'h11); preload(2, 8'h00); preload(3, 8'h0F);
    preload(4, 8'h80); preload(5, 8'hF1); preload(6, 8'h01); preload(7, 8'h00);
    @(negedge clk); rst_n = 1'b1;

    issue(3'd0, 3'd7, 3'd3, 3'd5, "add");
    wait_wb(2, 3'd7, 8'h00, 1'b1, 1'b1, "add");

    preload(3, 8'h05); preload(5, 8'h07);
    issue(3'd1, 3'd2, 3'd3, 3'd5, "sub");
    wait_wb(2, 3'd2, 8'hFE, 1'b0, 1'b1, "sub");
    chk("sub_rf", 16'(rf_mem[2]), 16'h00FE);

    issue(3'd5, 3'd1, 3'd4, 3'd6, "slt");
    wait_wb(2, 3'd1, 8'h01, 1'b0, 1'b0, "slt");

    issue(3'd4, 3'd0, 3'd4, 3'd6, "xor");
    wait_wb(2, 3'd0, 8'h81, 1'b0, 1'b0, "xor");

    preload(3, 8'h0D); preload(5, 8'h0B);
    issue(3'd6, 3'd6, 3'd3, 3'd5, "mul1");
    wait_wb(10, 3'd6, 8'h8F, 1'b0, 1'b0, "mul1");

    preload(3, 8'h20); preload(5, 8'h10);
    issue(3'd6, 3'd7, 3'd3, 3'd5, "mul2");
    wait_wb(10, 3'd7, 8'h00, 1'b1, 1'b1, "mul2");

    issue(3'd7, 3'd1, 3'd3, 3'd5, "nop");
    chk("nop_rd_done", 16'(done), 16'h0);
    step(1);
    chk("nop_ex_done", 16'(done), 16'h1);
    chk("nop_ex_we", 16'(rf_write_enable), 16'h0);
    step(1);
    chk("nop_ready", 16'(in_ready), 16'h1);
    chk("nop_done_low", 16'(done), 16'h0);
    chk("nop_flags", {14'h0, zero_flag, carry_flag}, 16'h3);
    chk("nop_hold", {5'h0, rf_write_port, rf_write_data}, {5'h0, 3'd7, 8'h00});
    chk("nop_rf", 16'(rf_mem[1]), 16'h0001);

    // Back-to-back with in_valid held; each reads the previous destination.
    @(negedge clk);
    opcode = 3'd0; rd = 3'd1; rs1 = 3'd3; rs2 = 3'd5; in_valid = 1'b1;
    step(1);
    chk("b2b1_busy", 16'(busy), 16'h1);
    opcode = 3'd1; rd = 3'd2; rs1 = 3'd1; rs2 = 3'd5;
    step(2);
    chk("b2b1_wb", {4'h0, rf_write_enable, rf_write_port, rf_write_data}, {4'h1, 3'd1, 8'h30});
    step(1);
    chk("b2b1_ready", 16'(in_ready), 16'h1);
    step(1);
    chk("b2b2_busy", 16'(busy), 16'h1);
    opcode = 3'd3; rd = 3'd0; rs1 = 3'd2; rs2 = 3'd6;
    step(2);
    chk("b2b2_wb", {4'h0, rf_write_enable, rf_write_port, rf_write_data}, {4'h1, 3'd2, 8'h20});
    chk("b2b2_carry", 16'(carry_flag), 16'h0);
    step(1);
    chk("b2b2_ready", 16'(in_ready), 16'h1);
    step(1);
    chk("b2b3_busy", 16'(busy), 16'h1);
    in_valid = 1'b0;
    step(2);
    chk("b2b3_wb", {4'h0, rf_write_enable, rf_write_port, rf_write_data}, {4'h1, 3'd0, 8'hAF});
    step(1);
    chk("b2b3_ready", 16'(in_ready), 16'h1);

    // Reset during the fourth multiply step.
    issue(3'd6, 3'd2, 3'd3, 3'd5, "mulrst");
    we_snap = we_cnt; done_snap = done_cnt;
    step(5);
    chk("mulrst_busy", 16'(busy), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mulrst_ready", 16'(in_ready), 16'h1);
    chk("mulrst_we", 16'(rf_write_enable), 16'h0);
    chk("mulrst_done", 16'(done), 16'h0);
    chk("mulrst_flags", {14'h0, zero_flag, carry_flag}, 16'h0);
    @(posedge clk);
    @(negedge clk);
    opcode = 3'd0; rd = 3'd0; rs1 = 3'd6; rs2 = 3'd4; in_valid = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("postrst_accept", 16'(busy), 16'h1);
    chk("mulrst_no_we", 16'(we_cnt - we_snap), 16'h0);
    chk("mulrst_no_done", 16'(done_cnt - done_snap), 16'h0);
    chk("mulrst_rf", 16'(rf_mem[2]), 16'h0020);
    wait_wb(2, 3'd0, 8'h0F, 1'b0, 1'b1, "postrst_add");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
